hs32_fetch: RTL and testbench

- Instruction fetch front end for hs32_pipeline; the transmitting end of the pipeline's valid_i/ready_o/op_i instruction stream.
- Masters a single-outstanding memory bus and buffers fetched words in a small prefetch FIFO.
- Presents each word and its PC to the pipeline under valid/ready handshaking.
- Accepts a jump/flush request that redirects fetch and discards all stale words.

---
 rtl/hs32_fetch_if.sv | 26 ++
 rtl/hs32_fetch.sv | 125 ++++++++++++
 tb/tb_hs32_fetch.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/hs32_fetch_if.sv
// rtl/hs32_fetch_if.sv - fetch bus and instruction stream bundle for hs32_fetch
interface hs32_fetch_if;
  // memory bus side
  logic [31:0] addr_o;
  logic        stb_o;
  logic        ack_i;
  logic [31:0] dat_i;
  // instruction stream to the pipeline
  logic        valid_o;
  logic        ready_i;
  logic [31:0] op_o;
  logic [31:0] pc_o;
  // redirect request
  logic        jmp_i;
  logic [31:0] jmp_addr_i;

  modport master (
    output addr_o, stb_o, valid_o, op_o, pc_o,
    input  ack_i, dat_i, ready_i, jmp_i, jmp_addr_i
  );

  modport slave (
    input  addr_o, stb_o, valid_o, op_o, pc_o,
    output ack_i, dat_i, ready_i, jmp_i, jmp_addr_i
  );
endinterface

// File: rtl/hs32_fetch.sv
// rtl/hs32_fetch.sv - instruction fetch front end with prefetch FIFO and redirect
module hs32_fetch #(
  parameter int          DEPTH     = 4,
  parameter logic [31:0] RESET_VEC = 32'h0000_0000
) (
  input logic         clk,
  input logic         reset,
  hs32_fetch_if.master bus
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, REQ, DISCARD} state_t;

  state_t         state, state_nxt;
  logic [31:0]    addr_q, addr_nxt;
  logic [31:0]    pc_q, pc_nxt;

  logic [31:0]    op_mem [DEPTH];
  logic [31:0]    pc_mem [DEPTH];
  logic [AW-1:0]  wr_ptr, rd_ptr;
  logic [CW-1:0]  count;

  logic [31:0]    jmp_tgt;
  logic           push, pop, room_after;
  logic           unused_jmp_lsb;

  assign jmp_tgt        = {bus.jmp_addr_i[31:2], 2'b00};
  assign unused_jmp_lsb = ^bus.jmp_addr_i[1:0];

  // A word is only kept when it arrives in REQ and no redirect is happening.
  assign pop        = (count != '0) && bus.ready_i;
  assign push       = (state == REQ) && bus.ack_i && !bus.jmp_i;
  // After this push, is there still a free slot for the next request?
  assign room_after = pop || (count < (DEPTH_C - CW'(1)));

  assign bus.stb_o   = (state != IDLE);
  assign bus.addr_o  = addr_q;
  assign bus.valid_o = (count != '0);
  assign bus.op_o    = op_mem[rd_ptr];
  assign bus.pc_o    = pc_mem[rd_ptr];

  // Next state and next bus/fetch address; addr_q only moves on an ack or when starting a request.
  always_comb begin
    state_nxt = state;
    addr_nxt  = addr_q;
    pc_nxt    = pc_q;
    case (state)
      IDLE: begin
        if (bus.jmp_i) begin
          state_nxt = REQ;
          addr_nxt  = jmp_tgt;
          pc_nxt    = jmp_tgt;
        end else if (count < DEPTH_C) begin
          state_nxt = REQ;
          addr_nxt  = pc_q;
        end
      end
      REQ: begin
        if (bus.jmp_i) begin
          pc_nxt = jmp_tgt;
          if (bus.ack_i) begin
            state_nxt = REQ;
            addr_nxt  = jmp_tgt;
          end else begin
            state_nxt = DISCARD;
          end
        end else if (bus.ack_i) begin
          pc_nxt    = addr_q + 32'd4;
          addr_nxt  = addr_q + 32'd4;
          state_nxt = room_after ? REQ : IDLE;
        end
      end
      DISCARD: begin
        if (bus.jmp_i) pc_nxt = jmp_tgt;
        if (bus.ack_i) begin
          state_nxt = REQ;
          addr_nxt  = bus.jmp_i ? jmp_tgt : pc_q;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // FSM state and address registers; reset abandons any outstanding request.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      addr_q <= RESET_VEC;
      pc_q   <= RESET_VEC;
    end else begin
      state  <= state_nxt;
      addr_q <= addr_nxt;
      pc_q   <= pc_nxt;
    end
  end

  // FIFO pointers and occupancy; a redirect empties the FIFO outright.
  always_ff @(posedge clk) begin
    if (reset || bus.jmp_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // FIFO storage: each entry holds the fetched word and the address it came from.
  always_ff @(posedge clk) begin
    if (push) begin
      op_mem[wr_ptr] <= bus.dat_i;
      pc_mem[wr_ptr] <= addr_q;
    end
  end

endmodule

// File: tb/tb_hs32_fetch.sv
// tb/tb_hs32_fetch.sv - directed self-checking bench for hs32_fetch
module tb_hs32_fetch;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_chk = 0;
  int   n_err = 0;
  int   lat = 0;
  int   wcnt = 0;
  int   ack_cnt = 0;

  hs32_fetch_if bus ();

  hs32_fetch #(.DEPTH(4), .RESET_VEC(32'h0000_0000)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // memory model: word at address a is 0x1000_0000 + a/4, acked after lat wait cycles
  always_comb begin
    bus.ack_i = bus.stb_o && (wcnt >= lat);
    bus.dat_i = 32'h1000_0000 + {2'b00, bus.addr_o[31:2]};
  end

  // wait-cycle and ack counters for the memory model
  always @(posedge clk) begin
    if (reset || !bus.stb_o || bus.ack_i) wcnt <= 0;
    else wcnt <= wcnt + 1;
    if (reset) ack_cnt <= 0;
    else if (bus.stb_o && bus.ack_i) ack_cnt <= ack_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic do_reset(input int lat_v, input logic rdy);
    reset       = 1'b1;
    lat         = lat_v;
    bus.ready_i = rdy;
    bus.jmp_i   = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // wait (bounded) for the next instruction with ready_i=1 and check it against the memory model
  task automatic wait_word(input logic [31:0] exp_pc);
    int n = 0;
    while (bus.valid_o !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("word_valid", 32'(bus.valid_o), 32'd1);
    chk("word_pc", bus.pc_o, exp_pc);
    chk("word_op", bus.op_o, 32'h1000_0000 + (exp_pc >> 2));
    @(negedge clk);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] exp_pc;
    logic [31:0] prev_addr;
    logic        prev_hold;
    int          last_cyc;
    logic        found;

    bus.ready_i    = 1'b1;
    bus.jmp_i      = 1'b0;
    bus.jmp_addr_i = 32'h0;

    // 1: reset state, then streaming at one word per cycle
    @(negedge clk);
    @(negedge clk);
    chk("rst_stb", 32'(bus.stb_o), 32'd0);
    chk("rst_valid", 32'(bus.valid_o), 32'd0);
    chk("rst_addr", bus.addr_o, 32'h0);
    reset = 1'b0;
    @(negedge clk);
    chk("t1_first_stb", 32'(bus.stb_o), 32'd1);
    chk("t1_first_addr", bus.addr_o, 32'h0);
    chk("t1_no_valid_yet", 32'(bus.valid_o), 32'd0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("t1_valid", 32'(bus.valid_o), 32'd1);
      chk("t1_op", bus.op_o, 32'h1000_0000 + 32'(i));
      chk("t1_pc", bus.pc_o, 32'(4 * i));
      chk("t1_addr", bus.addr_o, 32'(4 * (i + 1)));
    end

    // 2: stalled consumer fills exactly DEPTH entries, then drains in order
    do_reset(0, 1'b0);
    repeat (10) @(negedge clk);
    chk("t2_acks", 32'(ack_cnt), 32'd4);
    chk("t2_stb_idle", 32'(bus.stb_o), 32'd0);
    chk("t2_valid", 32'(bus.valid_o), 32'd1);
    chk("t2_head_op", bus.op_o, 32'h1000_0000);
    chk("t2_head_pc", bus.pc_o, 32'h0);
    bus.ready_i = 1'b1;
    for (int i = 0; i < 8; i++) wait_word(32'(4 * i));

    // 3: three wait states per request; bus held stable, one word per 4 cycles
    do_reset(3, 1'b1);
    exp_pc    = 32'h0;
    prev_hold = 1'b0;
    prev_addr = 32'h0;
    last_cyc  = -1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (prev_hold) begin
        chk("t3_hold_stb", 32'(bus.stb_o), 32'd1);
        chk("t3_hold_addr", bus.addr_o, prev_addr);
      end
      if (bus.valid_o) begin
        chk("t3_pc", bus.pc_o, exp_pc);
        chk("t3_op", bus.op_o, 32'h1000_0000 + (exp_pc >> 2));
        if (last_cyc >= 0) chk("t3_gap", 32'(c - last_cyc), 32'd4);
        last_cyc = c;
        exp_pc   = exp_pc + 32'd4;
      end
      prev_hold = bus.stb_o && !bus.ack_i;
      prev_addr = bus.addr_o;
    end
    chk("t3_words", exp_pc >> 2, 32'd9);

    // 4: jump while a request to 0x10 is still waiting
    do_reset(3, 1'b1);
    found = 1'b0;
    for (int c = 0; c < 40 && !found; c++) begin
      @(negedge clk);
      if (bus.stb_o && bus.addr_o == 32'h10 && wcnt == 1) found = 1'b1;
    end
    chk("t4_found", 32'(found), 32'd1);
    bus.jmp_i      = 1'b1;
    bus.jmp_addr_i = 32'h0000_0103;
    @(negedge clk);
    bus.jmp_i = 1'b0;
    chk("t4_hold_stb", 32'(bus.stb_o), 32'd1);
    chk("t4_hold_addr", bus.addr_o, 32'h10);
    chk("t4_flushed", 32'(bus.valid_o), 32'd0);
    @(negedge clk);
    chk("t4_ack_addr", bus.addr_o, 32'h10);
    chk("t4_ack", 32'(bus.ack_i), 32'd1);
    @(negedge clk);
    chk("t4_new_addr", bus.addr_o, 32'h100);
    chk("t4_new_stb", 32'(bus.stb_o), 32'd1);
    chk("t4_no_stale", 32'(bus.valid_o), 32'd0);
    wait_word(32'h100);
    wait_word(32'h104);

    // 5: jump coinciding with an ack and a pop handshake
    do_reset(0, 1'b1);
    repeat (3) @(negedge clk);
    chk("t5_pre_valid", 32'(bus.valid_o), 32'd1);
    chk("t5_pre_ack", 32'(bus.ack_i), 32'd1);
    chk("t5_popped_pc", bus.pc_o, 32'h4);
    chk("t5_popped_op", bus.op_o, 32'h1000_0001);
    chk("t5_acked_addr", bus.addr_o, 32'h8);
    bus.jmp_i      = 1'b1;
    bus.jmp_addr_i = 32'h0000_0200;
    @(negedge clk);
    bus.jmp_i = 1'b0;
    chk("t5_empty", 32'(bus.valid_o), 32'd0);
    chk("t5_stb", 32'(bus.stb_o), 32'd1);
    chk("t5_addr", bus.addr_o, 32'h200);
    wait_word(32'h200);
    wait_word(32'h204);

    // 6: reset in the middle of a request with three words buffered
    do_reset(0, 1'b0);
    repeat (4) @(negedge clk);
    chk("t6_pre_stb", 32'(bus.stb_o), 32'd1);
    chk("t6_pre_addr", bus.addr_o, 32'hC);
    chk("t6_pre_head", bus.op_o, 32'h1000_0000);
    reset = 1'b1;
    @(negedge clk);
    chk("t6_stb", 32'(bus.stb_o), 32'd0);
    chk("t6_valid", 32'(bus.valid_o), 32'd0);
    chk("t6_addr", bus.addr_o, 32'h0);
    reset       = 1'b0;
    bus.ready_i = 1'b1;
    wait_word(32'h0);
    wait_word(32'h4);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
